// File: rtl/rx_gen3_descrambler.sv
// Per-lane Gen3 128b/130b receive descrambler: follows block framing from the sync header,
// descrambles Data blocks and TS1/TS2 payloads, and applies the SKP/EIEOS LFSR rules.
module rx_gen3_descrambler #(
   parameter logic [23:0] SEED_DEFAULT = 24'h1DBFBC
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic [2:0]  gen,
   input  logic        turnOff,
   input  logic [23:0] seedValue,
   input  logic [31:0] RxData,
   input  logic        RxDataValid,
   input  logic        RxStartBlock,
   input  logic [1:0]  RxSyncHeader,
   output logic [31:0] DataOut,
   output logic        DataValidOut,
   output logic        StartBlockOut,
   output logic [1:0]  SyncHeaderOut,
   output logic        BlockErr,
   output logic        SyncErr
);
   typedef enum logic [1:0] {WAIT_BLK, DATA_BLK, OS_BLK} state_t;
   typedef enum logic [1:0] {OS_SKP, OS_EIEOS, OS_TS, OS_OTHER} os_t;

   // Galois form of x^23+x^21+x^16+x^8+x^5+x^2+1 (the x^0 term is the feedback into bit 0)
   localparam logic [22:0] LFSR_TAPS = 23'h210124;

   state_t      state_reg, state_next;
   os_t         os_reg, os_next;
   logic [1:0]  blk_cnt_reg, blk_cnt_next;
   logic [22:0] lfsr_reg, lfsr_next, lfsr_adv, seed_eff;
   logic [31:0] keystream, data_next;
   logic [3:0]  sym_xor, xor_en;
   logic [1:0]  cur_cnt;
   logic        advance, load_seed, block_err, sync_err, proc_blk, strict_blk, bypass;

   function automatic logic [22:0] lfsr_step(input logic [22:0] s);
      return {s[21:0], s[22]} ^ (s[22] ? LFSR_TAPS : 23'd0);
   endfunction

   function automatic os_t os_decode(input logic [7:0] sym);
      case (sym)
         8'hAA:        return OS_SKP;
         8'h00:        return OS_EIEOS;
         8'h1E, 8'h2D: return OS_TS;
         default:      return OS_OTHER;
      endcase
   endfunction

   // An all-zero seed would lock the LFSR at zero, so it means "seed not programmed yet".
   assign seed_eff   = (seedValue != 24'd0) ? seedValue[22:0] : SEED_DEFAULT[22:0];
   assign bypass     = turnOff || (gen != 3'd3);
   assign strict_blk = (state_reg == DATA_BLK) || ((state_reg == OS_BLK) && (os_reg != OS_SKP));
   assign cur_cnt    = RxStartBlock ? 2'd0 : blk_cnt_reg;

   always_comb begin : keystream_walk
      logic [22:0] walk;
      walk      = lfsr_reg;
      keystream = '0;
      for (int i = 0; i < 32; i++) begin
         keystream[i] = walk[22];
         walk         = lfsr_step(walk);
      end
      lfsr_adv = walk;
   end

   always_comb begin
      state_next   = state_reg;
      os_next      = os_reg;
      blk_cnt_next = blk_cnt_reg;
      proc_blk     = 1'b0;
      block_err    = 1'b0;
      sync_err     = 1'b0;
      advance      = 1'b0;
      load_seed    = 1'b0;
      sym_xor      = 4'h0;
      if (RxDataValid) begin
         if (RxStartBlock) begin
            block_err = strict_blk && (blk_cnt_reg != 2'd0);
            if (RxSyncHeader == 2'b10) begin
               state_next   = DATA_BLK;
               blk_cnt_next = 2'd1;
               proc_blk     = 1'b1;
            end else if (RxSyncHeader == 2'b01) begin
               state_next   = OS_BLK;
               os_next      = os_decode(RxData[7:0]);
               blk_cnt_next = 2'd1;
               proc_blk     = 1'b1;
            end else begin
               // Bad header: keep the scrambler in step as if a data block went by
               sync_err     = 1'b1;
               state_next   = WAIT_BLK;
               blk_cnt_next = 2'd0;
               advance      = 1'b1;
            end
         end else if (state_reg != WAIT_BLK) begin
            if (strict_blk && (blk_cnt_reg == 2'd0)) begin
               block_err  = 1'b1;
               state_next = WAIT_BLK;
            end else begin
               blk_cnt_next = blk_cnt_reg + 2'd1;
               proc_blk     = 1'b1;
            end
         end
      end
      if (proc_blk) begin
         case (state_next)
            DATA_BLK: begin
               sym_xor = 4'hF;
               advance = 1'b1;
            end
            OS_BLK: begin
               case (os_next)
                  OS_SKP:   advance = 1'b0;
                  OS_EIEOS: begin
                     advance   = 1'b1;
                     load_seed = (cur_cnt == 2'd3);
                  end
                  OS_TS: begin
                     advance = 1'b1;
                     case (cur_cnt)
                        2'd0:    sym_xor = 4'b1110;
                        2'd3:    sym_xor = 4'b0011;
                        default: sym_xor = 4'b1111;
                     endcase
                  end
                  default:  advance = 1'b1;
               endcase
            end
            default: sym_xor = 4'h0;
         endcase
      end
   end

   always_comb begin
      if (bypass || load_seed)
         lfsr_next = seed_eff;
      else if (advance)
         lfsr_next = lfsr_adv;
      else
         lfsr_next = lfsr_reg;
   end

   assign xor_en = sym_xor & {4{~bypass}};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sym
         assign data_next[gi*8 +: 8] = RxData[gi*8 +: 8] ^ (xor_en[gi] ? keystream[gi*8 +: 8] : 8'h00);
      end
   endgenerate

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_reg     <= WAIT_BLK;
         os_reg        <= OS_OTHER;
         blk_cnt_reg   <= 2'd0;
         lfsr_reg      <= seed_eff;
         DataOut       <= 32'd0;
         DataValidOut  <= 1'b0;
         StartBlockOut <= 1'b0;
         SyncHeaderOut <= 2'b00;
         BlockErr      <= 1'b0;
         SyncErr       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         os_reg        <= os_next;
         blk_cnt_reg   <= blk_cnt_next;
         lfsr_reg      <= lfsr_next;
         DataOut       <= data_next;
         DataValidOut  <= RxDataValid;
         StartBlockOut <= RxDataValid && RxStartBlock;
         if (RxDataValid && RxStartBlock)
            SyncHeaderOut <= RxSyncHeader;
         BlockErr      <= block_err;
         SyncErr       <= sync_err;
      end
   end
endmodule

// File: tb/tb_rx_gen3_descrambler.sv
// Bench for rx_gen3_descrambler: directed TX-loopback vector table, then random block
// streams checked against a symbol-level reference model of the receive rules.
module tb_rx_gen3_descrambler;
   logic        pclk = 1'b0;
   logic        reset;
   logic [2:0]  gen;
   logic        turnOff;
   logic [23:0] seedValue;
   logic [31:0] RxData;
   logic        RxDataValid, RxStartBlock;
   logic [1:0]  RxSyncHeader;
   logic [31:0] DataOut;
   logic        DataValidOut, StartBlockOut;
   logic [1:0]  SyncHeaderOut;
   logic        BlockErr, SyncErr;

   rx_gen3_descrambler #(.SEED_DEFAULT(24'h1DBFBC)) dut (
      .pclk(pclk), .reset(reset), .gen(gen), .turnOff(turnOff), .seedValue(seedValue),
      .RxData(RxData), .RxDataValid(RxDataValid), .RxStartBlock(RxStartBlock),
      .RxSyncHeader(RxSyncHeader), .DataOut(DataOut), .DataValidOut(DataValidOut),
      .StartBlockOut(StartBlockOut), .SyncHeaderOut(SyncHeaderOut),
      .BlockErr(BlockErr), .SyncErr(SyncErr)
   );

   always #5 pclk = ~pclk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Multiply the LFSR state by x modulo G(x) = x^23+x^21+x^16+x^8+x^5+x^2+1
   function automatic logic [22:0] mulx(input logic [22:0] s);
      logic [23:0] t;
      t = {s, 1'b0};
      if (t[23]) t = t ^ 24'hA10125;
      return t[22:0];
   endfunction

   function automatic logic [22:0] seed_of(input logic [23:0] sv);
      return (sv != 24'd0) ? sv[22:0] : 23'h1DBFBC;
   endfunction

   function automatic int classify(input logic [7:0] s);
      if (s == 8'hAA) return 0;
      if (s == 8'h00) return 1;
      if (s == 8'h1E || s == 8'h2D) return 2;
      return 3;
   endfunction

   // ---------------- reference model (symbol positions within the block) ----------------
   logic [22:0] m_lfsr;
   int          m_mode;   // 0 outside a block, 1 data block, 2 ordered set
   int          m_os;     // 0 SKP, 1 EIEOS, 2 TS1/TS2, 3 other
   int          m_pos;    // symbols already consumed in the current block
   logic [1:0]  m_hdr;
   logic [31:0] e_data;
   logic        e_valid, e_start, e_be, e_se;
   logic [1:0]  e_hdr;

   task automatic ref_cycle(input logic rst, input logic v, input logic st, input logic [1:0] hdr,
                            input logic [31:0] d, input logic [2:0] g, input logic toff,
                            input logic [23:0] sv);
      logic byp, strict, do_proc, scr, adv;
      int idx;
      if (rst) begin
         {e_data, e_valid, e_start, e_be, e_se, e_hdr} = '0;
         m_lfsr = seed_of(sv); m_mode = 0; m_os = 3; m_pos = 0; m_hdr = 2'b00;
         return;
      end
      byp = toff || (g != 3'd3);
      e_valid = v; e_start = v && st; e_data = d; e_be = 1'b0; e_se = 1'b0;
      if (v) begin
         strict  = (m_mode == 1) || (m_mode == 2 && m_os != 0);
         do_proc = 1'b0;
         if (st) begin
            e_be  = strict && ((m_pos % 16) != 0);
            m_hdr = hdr;
            m_pos = 0;
            if (hdr == 2'b10) begin
               m_mode = 1; do_proc = 1'b1;
            end else if (hdr == 2'b01) begin
               m_mode = 2; m_os = classify(d[7:0]); do_proc = 1'b1;
            end else begin
               e_se = 1'b1; m_mode = 0;
               for (int i = 0; i < 32; i++) m_lfsr = mulx(m_lfsr);
            end
         end else if (m_mode != 0) begin
            if (strict && m_pos == 16) begin
               e_be = 1'b1; m_mode = 0; m_pos = 0;
            end else do_proc = 1'b1;
         end
         if (do_proc) begin
            for (int k = 0; k < 4; k++) begin
               idx = m_pos + k;
               scr = (m_mode == 1) || (m_mode == 2 && m_os == 2 && idx >= 1 && idx <= 13);
               adv = !(m_mode == 2 && m_os == 0);
               for (int b = 0; b < 8; b++) begin
                  if (scr && !byp) e_data[8*k+b] = e_data[8*k+b] ^ m_lfsr[22];
                  if (adv) m_lfsr = mulx(m_lfsr);
               end
            end
            m_pos += 4;
            if (m_mode == 2 && m_os == 1 && m_pos == 16) m_lfsr = seed_of(sv);
         end
      end
      e_hdr = m_hdr;
      if (byp) m_lfsr = seed_of(sv);
   endtask

   task automatic rnd_cycle(input logic rst, input logic v, input logic st, input logic [1:0] hdr,
                            input logic [31:0] d);
      reset = rst; RxDataValid = v; RxStartBlock = st; RxSyncHeader = hdr; RxData = d;
      ref_cycle(rst, v, st, hdr, d, gen, turnOff, seedValue);
      @(posedge pclk);
      @(negedge pclk);
      chk("rnd data",  DataOut, e_data);
      chk("rnd valid", 32'(DataValidOut), 32'(e_valid));
      chk("rnd start", 32'(StartBlockOut), 32'(e_start));
      chk("rnd hdr",   32'(SyncHeaderOut), 32'(e_hdr));
      chk("rnd blkerr", 32'(BlockErr), 32'(e_be));
      chk("rnd syncerr", 32'(SyncErr), 32'(e_se));
      $display("rnd rst=%0b v=%0b st=%0b hdr=%b in=%h out=%h be=%0b se=%0b",
               rst, v, st, hdr, d, DataOut, BlockErr, SyncErr);
   endtask

   // ---------------- directed table: remote TX is told exactly what to scramble ----------------
   typedef struct {
      logic        v, st;
      logic [1:0]  hdr;
      logic [31:0] data;   // plaintext; also the required DataOut
      logic [3:0]  txm;    // symbols the transmitter scrambles
      logic        adv;    // transmitter LFSR advances 32 bits
      logic        rs;     // transmitter reloads its seed afterwards
      logic        be, se;
   } vec_t;

   vec_t        vecs[$];
   int          byte_ctr = 0;
   logic [22:0] tx_lfsr;
   logic [1:0]  last_hdr;

   task automatic add(input logic v, input logic st, input logic [1:0] hdr, input logic [31:0] data,
                      input logic [3:0] txm, input logic adv, input logic rs, input logic be,
                      input logic se);
      vec_t t;
      t.v = v; t.st = st; t.hdr = hdr; t.data = data; t.txm = txm;
      t.adv = adv; t.rs = rs; t.be = be; t.se = se;
      vecs.push_back(t);
   endtask

   task automatic add_dblk();
      logic [31:0] w;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = 8'(byte_ctr);
            byte_ctr++;
         end
         add(1'b1, c == 0, 2'b10, w, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic tbl_cycle(input int i);
      vec_t        t;
      logic [22:0] s;
      logic [31:0] w;
      t = vecs[i];
      s = tx_lfsr;
      w = t.data;
      for (int b = 0; b < 32; b++) begin
         if (t.txm[b/8]) w[b] = w[b] ^ s[22];
         s = mulx(s);
      end
      if (t.adv) tx_lfsr = s;
      if (t.rs) tx_lfsr = seed_of(seedValue);
      RxDataValid = t.v; RxStartBlock = t.st; RxSyncHeader = t.hdr; RxData = w;
      if (t.v && t.st) last_hdr = t.hdr;
      @(posedge pclk);
      @(negedge pclk);
      chk($sformatf("tbl[%0d] data", i), DataOut, t.data);
      chk($sformatf("tbl[%0d] valid", i), 32'(DataValidOut), 32'(t.v));
      chk($sformatf("tbl[%0d] start", i), 32'(StartBlockOut), 32'(t.v && t.st));
      chk($sformatf("tbl[%0d] hdr", i), 32'(SyncHeaderOut), 32'(last_hdr));
      chk($sformatf("tbl[%0d] blkerr", i), 32'(BlockErr), 32'(t.be));
      chk($sformatf("tbl[%0d] syncerr", i), 32'(SyncErr), 32'(t.se));
      $display("tbl %0d v=%0b st=%0b hdr=%b wire=%h out=%h be=%0b se=%0b",
               i, t.v, t.st, t.hdr, w, DataOut, BlockErr, SyncErr);
   endtask

   initial begin
      int          kind, ncyc;
      logic        has_st, do_rst;
      logic [1:0]  hdr;
      logic [7:0]  sym0;
      logic [31:0] d;

      gen = 3'd3; turnOff = 1'b0; seedValue = 24'h1DBFBC;
      reset = 1'b1; RxDataValid = 1'b1; RxStartBlock = 1'b1; RxSyncHeader = 2'b10; RxData = $urandom;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      chk("reset data", DataOut, 32'd0);
      chk("reset valid", 32'(DataValidOut), 32'd0);
      chk("reset start", 32'(StartBlockOut), 32'd0);
      chk("reset hdr", 32'(SyncHeaderOut), 32'd0);
      chk("reset blkerr", 32'(BlockErr), 32'd0);
      chk("reset syncerr", 32'(SyncErr), 32'd0);
      reset = 1'b0;
      tx_lfsr = seed_of(seedValue);
      last_hdr = 2'b00;

      // scrambled zeros, then 8 loopback data blocks of incrementing bytes
      for (int c = 0; c < 4; c++) add(1'b1, c == 0, 2'b10, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (8) add_dblk();
      // 8-symbol SKP between data blocks
      add_dblk();
      add(1'b1, 1'b1, 2'b01, 32'hAAAAAAAA, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b01, 32'h563412E1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_dblk();
      // EIEOS reloads the seed on its last cycle
      for (int c = 0; c < 4; c++) add(1'b1, c == 0, 2'b01, 32'hFF00FF00, 4'h0, 1'b1, c == 3, 1'b0, 1'b0);
      add_dblk();
      // TS1: symbol 0 and 14-15 in the clear
      add(1'b1, 1'b1, 2'b01, 32'h7A6B5C1E, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b01, 32'h01234567, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b01, 32'h89ABCDEF, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b01, 32'h5A5A1357, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
      add_dblk();
      // early RxStartBlock, then a missing one
      add(1'b1, 1'b1, 2'b10, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 2'b10, 32'h55667788, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 2'b10, 32'h99AABBCC, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b10, 32'hDDEEFF00, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b10, 32'h13579BDF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b10, 32'h2468ACE0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      add_dblk();
      // invalid header, one idle cycle, back in lock
      add(1'b1, 1'b1, 2'b11, 32'hCAFEF00D, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 2'b10, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_dblk();
      // RxDataValid low for 3 cycles mid-block
      add(1'b1, 1'b1, 2'b10, 32'h0BADC0DE, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) add(1'b0, 1'b0, 2'b10, 32'h600DF00D, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b10, 32'h0F1E2D3C, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b10, 32'h4B5A6978, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'b10, 32'h8796A5B4, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      add_dblk();

      for (int i = 0; i < vecs.size(); i++) tbl_cycle(i);

      // random block streams against the reference model
      rnd_cycle(1'b1, 1'b1, 1'b0, 2'b00, $urandom);
      for (int b = 0; b < 160; b++) begin
         turnOff = ($urandom_range(0, 11) == 0);
         gen = ($urandom_range(0, 11) == 0) ? 3'd2 : 3'd3;
         if ($urandom_range(0, 7) == 0) seedValue = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
         do_rst = ($urandom_range(0, 39) == 0);
         kind = $urandom_range(0, 99);
         has_st = 1'b1; ncyc = 4; hdr = 2'b01; sym0 = 8'($urandom);
         if (kind < 35) hdr = 2'b10;
         else if (kind < 45) begin sym0 = 8'hAA; ncyc = $urandom_range(2, 6); end
         else if (kind < 55) sym0 = 8'h00;
         else if (kind < 70) sym0 = $urandom_range(0, 1) ? 8'h1E : 8'h2D;
         else if (kind < 78) sym0 = $urandom_range(0, 1) ? 8'h66 : 8'hE1;
         else if (kind < 84) begin hdr = $urandom_range(0, 1) ? 2'b11 : 2'b00; ncyc = 1; end
         else if (kind < 90) begin hdr = 2'b10; ncyc = $urandom_range(1, 3); end
         else begin has_st = 1'b0; hdr = 2'b10; ncyc = $urandom_range(1, 2); end
         for (int c = 0; c < ncyc; c++) begin
            if (c > 0 && $urandom_range(0, 9) == 0)
               repeat ($urandom_range(1, 3)) rnd_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
            d = $urandom;
            if (c == 0) d[7:0] = sym0;
            rnd_cycle(do_rst && c == 2, 1'b1, has_st && c == 0, hdr, d);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
